// File: rtl/execute_unit.sv
// ---------------------------------------------------------------------------
// execute_unit -- E stage of a five-stage RISC-V style pipeline plus the
// E->M pipeline register.
//
// Ports
//   CLK, RST                   rising-edge clock, synchronous active-high reset
//   RD1E, RD2E                 register-file read data
//   PCE, PCPlus4E, ImmExtE     instruction PC, PC+4, sign-extended immediate
//   ALUResultMH, ResultW       forwarded M-stage / W-stage results
//   RdE                        destination register
//   funct3E                    branch condition select
//   controlE                   [0] ALUSrc, [4:1] ALUControl,
//                              [6:5] flow (00 none, 01 branch, 10 jal, 11 jalr),
//                              [10:7] M-stage control
//   ForwardAE, ForwardBE       operand forwarding selects
//   PCTargetE, ALUResultE      combinational branch target / ALU result
//   PCSrcE                     next-PC select: 00 PC+4, 01 PCTargetE, 10 ALUResultE
//   ALUResultM, WriteDataM,
//   PCPlus4M, RdM, controlM    registered E->M outputs
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// execute_alu -- 32-bit ALU with comparison flags.
//   a, b      operands
//   ctl       operation select
//   result    operation result
//   zero      a == b
//   sign      signed a < b
//   slt       unsigned a < b
// The flags do not depend on ctl so the branch logic can use them whatever
// operation the decoder selected.
// ---------------------------------------------------------------------------
module execute_alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  ctl,
    output logic [31:0] result,
    output logic        zero,
    output logic        sign,
    output logic        slt
);
    logic [4:0] shamt;

    assign shamt = b[4:0];
    assign zero  = (a == b);
    assign sign  = ($signed(a) < $signed(b));
    assign slt   = (a < b);

    always_comb begin
        result = '0;
        unique case (ctl)
            4'b0000: result = a + b;
            4'b0001: result = a - b;
            4'b0010: result = a & b;
            4'b0011: result = a | b;
            4'b0100: result = a ^ b;
            4'b0101: result = {31'b0, sign};
            4'b0110: result = {31'b0, slt};
            4'b0111: result = a << shamt;
            4'b1000: result = a >> shamt;
            4'b1001: result = $unsigned($signed(a) >>> shamt);
            4'b1010: result = b;
            default: result = '0;
        endcase
    end
endmodule

module execute_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] RD1E,
    input  logic [31:0] RD2E,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [31:0] ImmExtE,
    input  logic [31:0] ALUResultMH,
    input  logic [31:0] ResultW,
    input  logic [4:0]  RdE,
    input  logic [2:0]  funct3E,
    input  logic [10:0] controlE,
    input  logic [1:0]  ForwardAE,
    input  logic [1:0]  ForwardBE,
    output logic [31:0] PCTargetE,
    output logic [31:0] ALUResultE,
    output logic [1:0]  PCSrcE,
    output logic [31:0] ALUResultM,
    output logic [31:0] WriteDataM,
    output logic [31:0] PCPlus4M,
    output logic [4:0]  RdM,
    output logic [3:0]  controlM
);
    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [31:0] pc_plus4;
        logic [4:0]  rd;
        logic [3:0]  ctl;
    } m_reg_t;

    localparam logic [1:0] FLOW_NONE   = 2'b00;
    localparam logic [1:0] FLOW_BRANCH = 2'b01;
    localparam logic [1:0] FLOW_JAL    = 2'b10;

    // Control field decode
    logic       alu_src;
    logic [3:0] alu_ctl;
    logic [1:0] flow;

    assign alu_src = controlE[0];
    assign alu_ctl = controlE[4:1];
    assign flow    = controlE[6:5];

    // Operand forwarding; code 11 is unused and falls back to the register file
    logic [31:0] src_a, src_bo, src_b;

    always_comb begin
        src_a = RD1E;
        unique case (ForwardAE)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = ALUResultMH;
            default: src_a = RD1E;
        endcase
    end

    always_comb begin
        src_bo = RD2E;
        unique case (ForwardBE)
            2'b01:   src_bo = ResultW;
            2'b10:   src_bo = ALUResultMH;
            default: src_bo = RD2E;
        endcase
    end

    assign src_b = alu_src ? ImmExtE : src_bo;

    // ALU
    logic zero, sign, slt;

    execute_alu u_alu (
        .a      (src_a),
        .b      (src_b),
        .ctl    (alu_ctl),
        .result (ALUResultE),
        .zero   (zero),
        .sign   (sign),
        .slt    (slt)
    );

    assign PCTargetE = PCE + ImmExtE;

    // Branch resolution
    logic taken;

    always_comb begin
        taken = 1'b0;
        unique case (funct3E)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = sign;
            3'b101:  taken = ~sign;
            3'b110:  taken = slt;
            3'b111:  taken = ~slt;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        PCSrcE = 2'b00;
        unique case (flow)
            FLOW_NONE:   PCSrcE = 2'b00;
            FLOW_BRANCH: PCSrcE = {1'b0, taken};
            FLOW_JAL:    PCSrcE = 2'b01;
            default:     PCSrcE = 2'b10;   // jalr: target comes from the ALU
        endcase
    end

    // E->M pipeline register. Store data is the forwarded rs2 value, taken
    // before the immediate mux, so stores write the register operand.
    m_reg_t m_d;
    m_reg_t m_q = '0;

    assign m_d = '{alu_result: ALUResultE,
                   write_data: src_bo,
                   pc_plus4:   PCPlus4E,
                   rd:         RdE,
                   ctl:        controlE[10:7]};

    always_ff @(posedge CLK) begin
        if (RST) m_q <= '0;
        else     m_q <= m_d;
    end

    assign ALUResultM = m_q.alu_result;
    assign WriteDataM = m_q.write_data;
    assign PCPlus4M   = m_q.pc_plus4;
    assign RdM        = m_q.rd;
    assign controlM   = m_q.ctl;
endmodule

// File: tb/tb_execute_unit.sv
module tb_execute_unit;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE, ALUResultMH, ResultW;
    logic [4:0]  RdE;
    logic [2:0]  funct3E;
    logic [10:0] controlE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] PCTargetE, ALUResultE;
    logic [1:0]  PCSrcE;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic [3:0]  controlM;

    int checks = 0;
    int errors = 0;

    execute_unit dut (
        .CLK(CLK), .RST(RST),
        .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
        .ALUResultMH(ALUResultMH), .ResultW(ResultW), .RdE(RdE), .funct3E(funct3E),
        .controlE(controlE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .PCTargetE(PCTargetE), .ALUResultE(ALUResultE), .PCSrcE(PCSrcE),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
        .RdM(RdM), .controlM(controlM)
    );

    always #5 CLK = ~CLK;

    function automatic logic [10:0] ctl(input logic [3:0] mctl, input logic [1:0] flow,
                                        input logic [3:0] aluc, input logic src);
        return {mctl, flow, aluc, src};
    endfunction

    task automatic set_defaults();
        RD1E = 0; RD2E = 0; PCE = 0; PCPlus4E = 0; ImmExtE = 0;
        ALUResultMH = 0; ResultW = 0; RdE = 0; funct3E = 0;
        controlE = 0; ForwardAE = 0; ForwardBE = 0;
    endtask

    // Inputs change just after the falling edge; checks occur 1 ns later.
    task automatic settle();
        #1;
    endtask

    task automatic clock_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        set_defaults();
        #1;
        checks++;
        if ({ALUResultM, WriteDataM, PCPlus4M, RdM, controlM} !== '0) begin
            errors++;
            $display("FAIL powerup M regs got %h/%h/%h/%h/%h want all 0",
                     ALUResultM, WriteDataM, PCPlus4M, RdM, controlM);
        end
        @(negedge CLK);
        RST = 1; RD1E = 3; RD2E = 4; PCPlus4E = 32'h44; RdE = 5'd9;
        controlE = ctl(4'hA, 2'b00, 4'b0000, 1'b0);
        settle();
        checks++;
        if (ALUResultE !== 32'd7) begin
            errors++;
            $display("FAIL comb_during_reset ALUResultE got %h want 00000007", ALUResultE);
        end
        clock_edge();
        checks++;
        if ({ALUResultM, WriteDataM, PCPlus4M, RdM, controlM} !== '0) begin
            errors++;
            $display("FAIL reset M regs got %h/%h/%h/%h/%h want all 0",
                     ALUResultM, WriteDataM, PCPlus4M, RdM, controlM);
        end
        @(negedge CLK);
        RST = 0;
    endtask

    task automatic test_sub();
        @(negedge CLK);
        set_defaults();
        RD1E = 5; RD2E = 7; PCPlus4E = 32'h204; RdE = 5'd3;
        controlE = ctl(4'h5, 2'b01, 4'b0001, 1'b0);
        funct3E = 3'b100;
        settle();
        checks++;
        if (ALUResultE !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL sub_result got %h want fffffffe", ALUResultE);
        end
        checks++;
        if (PCSrcE !== 2'b01) begin
            errors++;
            $display("FAIL sub_sign_flag PCSrcE got %b want 01", PCSrcE);
        end
        funct3E = 3'b110;
        settle();
        checks++;
        if (PCSrcE !== 2'b01) begin
            errors++;
            $display("FAIL sub_slt_flag PCSrcE got %b want 01", PCSrcE);
        end
        clock_edge();
        checks++;
        if (ALUResultM !== 32'hFFFF_FFFE || WriteDataM !== 32'd7 || PCPlus4M !== 32'h204 ||
            RdM !== 5'd3 || controlM !== 4'h5) begin
            errors++;
            $display("FAIL sub_mreg got %h/%h/%h/%h/%h want fffffffe/00000007/00000204/03/5",
                     ALUResultM, WriteDataM, PCPlus4M, RdM, controlM);
        end
    endtask

    task automatic test_branch();
        @(negedge CLK);
        set_defaults();
        RD1E = 32'hFFFF_FFFF; RD2E = 1;
        controlE = ctl(4'h0, 2'b01, 4'b0001, 1'b0);
        funct3E = 3'b100; settle();
        checks++;
        if (PCSrcE !== 2'b01) begin
            errors++; $display("FAIL blt_taken PCSrcE got %b want 01", PCSrcE);
        end
        funct3E = 3'b110; settle();
        checks++;
        if (PCSrcE !== 2'b00) begin
            errors++; $display("FAIL bltu_not_taken PCSrcE got %b want 00", PCSrcE);
        end
        funct3E = 3'b111; settle();
        checks++;
        if (PCSrcE !== 2'b01) begin
            errors++; $display("FAIL bgeu_taken PCSrcE got %b want 01", PCSrcE);
        end
        funct3E = 3'b101; settle();
        checks++;
        if (PCSrcE !== 2'b00) begin
            errors++; $display("FAIL bge_not_taken PCSrcE got %b want 00", PCSrcE);
        end
        RD2E = 32'hFFFF_FFFF; funct3E = 3'b000; settle();
        checks++;
        if (PCSrcE !== 2'b01) begin
            errors++; $display("FAIL beq_taken PCSrcE got %b want 01", PCSrcE);
        end
        funct3E = 3'b001; settle();
        checks++;
        if (PCSrcE !== 2'b00) begin
            errors++; $display("FAIL bne_not_taken PCSrcE got %b want 00", PCSrcE);
        end
        funct3E = 3'b010; settle();
        checks++;
        if (PCSrcE !== 2'b00) begin
            errors++; $display("FAIL funct3_010_never PCSrcE got %b want 00", PCSrcE);
        end
        controlE = ctl(4'h0, 2'b00, 4'b0001, 1'b0); funct3E = 3'b000; settle();
        checks++;
        if (PCSrcE !== 2'b00) begin
            errors++; $display("FAIL flow_none PCSrcE got %b want 00", PCSrcE);
        end
    endtask

    task automatic test_forward();
        @(negedge CLK);
        set_defaults();
        RD1E = 32'hDEAD; RD2E = 32'hBEEF;
        ForwardAE = 2'b10; ALUResultMH = 32'h10;
        ForwardBE = 2'b01; ResultW = 32'h20;
        ImmExtE = 4;
        controlE = ctl(4'h3, 2'b00, 4'b0000, 1'b1);
        settle();
        checks++;
        if (ALUResultE !== 32'h14) begin
            errors++; $display("FAIL fwd_add got %h want 00000014", ALUResultE);
        end
        clock_edge();
        checks++;
        if (WriteDataM !== 32'h20 || ALUResultM !== 32'h14) begin
            errors++;
            $display("FAIL fwd_mreg WriteDataM got %h want 00000020, ALUResultM got %h want 00000014",
                     WriteDataM, ALUResultM);
        end
        @(negedge CLK);
        ForwardAE = 2'b11; ForwardBE = 2'b10;
        controlE = ctl(4'h0, 2'b00, 4'b0001, 1'b0);
        settle();
        checks++;
        if (ALUResultE !== 32'hDEAD - 32'h10) begin
            errors++; $display("FAIL fwd_11_rd1 got %h want %h", ALUResultE, 32'hDEAD - 32'h10);
        end
        ForwardAE = 2'b01; ForwardBE = 2'b00; settle();
        checks++;
        if (ALUResultE !== 32'h20 - 32'hBEEF) begin
            errors++; $display("FAIL fwd_01_resw got %h want %h", ALUResultE, 32'h20 - 32'hBEEF);
        end
    endtask

    task automatic test_target();
        @(negedge CLK);
        set_defaults();
        PCE = 32'h100; ImmExtE = 32'hFFFF_FFF8;
        RD1E = 32'h1000; ForwardAE = 2'b00;
        controlE = ctl(4'h0, 2'b10, 4'b0000, 1'b1);
        settle();
        checks++;
        if (PCTargetE !== 32'hF8) begin
            errors++; $display("FAIL pc_target got %h want 000000f8", PCTargetE);
        end
        checks++;
        if (PCSrcE !== 2'b01) begin
            errors++; $display("FAIL jal PCSrcE got %b want 01", PCSrcE);
        end
        controlE = ctl(4'h0, 2'b11, 4'b0000, 1'b1); settle();
        checks++;
        if (PCSrcE !== 2'b10 || ALUResultE !== 32'hFF8) begin
            errors++;
            $display("FAIL jalr PCSrcE got %b want 10, ALUResultE got %h want 00000ff8", PCSrcE, ALUResultE);
        end
    endtask

    task automatic test_alu_ops();
        logic [3:0]  ops [8]  = '{4'b1001, 4'b1000, 4'b1111, 4'b0111, 4'b0010, 4'b0011, 4'b0100, 4'b1010};
        logic [31:0] exp [8]  = '{32'hF800_0000, 32'h0800_0000, 32'h0, 32'h0,
                                  32'h0, 32'h8000_0004, 32'h8000_0004, 32'h4};
        @(negedge CLK);
        set_defaults();
        RD1E = 32'h8000_0000; RD2E = 4;
        for (int i = 0; i < 8; i++) begin
            controlE = ctl(4'h0, 2'b00, ops[i], 1'b0);
            settle();
            checks++;
            if (ALUResultE !== exp[i]) begin
                errors++;
                $display("FAIL alu_op_%b got %h want %h", ops[i], ALUResultE, exp[i]);
            end
        end
        // signed vs unsigned set-less-than on the same operands
        controlE = ctl(4'h0, 2'b00, 4'b0101, 1'b0); settle();
        checks++;
        if (ALUResultE !== 32'd1) begin
            errors++; $display("FAIL alu_slt got %h want 00000001", ALUResultE);
        end
        controlE = ctl(4'h0, 2'b00, 4'b0110, 1'b0); settle();
        checks++;
        if (ALUResultE !== 32'd0) begin
            errors++; $display("FAIL alu_sltu got %h want 00000000", ALUResultE);
        end
        RD1E = 32'h0000_0003; RD2E = 32'h0000_0024;   // shift amount uses low 5 bits only
        controlE = ctl(4'h0, 2'b00, 4'b0111, 1'b0); settle();
        checks++;
        if (ALUResultE !== 32'h30) begin
            errors++; $display("FAIL alu_sll_shamt got %h want 00000030", ALUResultE);
        end
    endtask

    task automatic test_reset_priority();
        @(negedge CLK);
        set_defaults();
        RD1E = 32'h1234; RD2E = 32'h55; PCPlus4E = 32'h808; RdE = 5'd31;
        controlE = ctl(4'hF, 2'b00, 4'b0000, 1'b0);
        clock_edge();
        checks++;
        if (ALUResultM !== 32'h1289 || WriteDataM !== 32'h55 || PCPlus4M !== 32'h808 ||
            RdM !== 5'd31 || controlM !== 4'hF) begin
            errors++;
            $display("FAIL preload_mreg got %h/%h/%h/%h/%h want 00001289/00000055/00000808/1f/f",
                     ALUResultM, WriteDataM, PCPlus4M, RdM, controlM);
        end
        @(negedge CLK);
        RST = 1;
        clock_edge();
        checks++;
        if ({ALUResultM, WriteDataM, PCPlus4M, RdM, controlM} !== '0) begin
            errors++;
            $display("FAIL reset_priority got %h/%h/%h/%h/%h want all 0",
                     ALUResultM, WriteDataM, PCPlus4M, RdM, controlM);
        end
        @(negedge CLK);
        RST = 0;
        RD1E = 32'h1; RD2E = 32'h2; PCPlus4E = 32'hC; RdE = 5'd7;
        controlE = ctl(4'h6, 2'b00, 4'b0000, 1'b0);
        clock_edge();
        checks++;
        if (ALUResultM !== 32'h3 || WriteDataM !== 32'h2 || PCPlus4M !== 32'hC ||
            RdM !== 5'd7 || controlM !== 4'h6) begin
            errors++;
            $display("FAIL resume_after_reset got %h/%h/%h/%h/%h want 00000003/00000002/0000000c/07/6",
                     ALUResultM, WriteDataM, PCPlus4M, RdM, controlM);
        end
    endtask

    initial begin
        test_reset();
        test_sub();
        test_branch();
        test_forward();
        test_target();
        test_alu_ops();
        test_reset_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/execute_unit.md
EXECUTE_UNIT -- requirements
Module: execute_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports CLK and RST.
REQ-002 CLK  input  1  rising-edge clock for the E->M pipeline register.
REQ-003 RST  input  1  synchronous active-high reset.
REQ-004 RD1E, RD2E  input  32 each  register-file read data.
REQ-005 PCE, PCPlus4E, ImmExtE  input  32 each  instruction PC, PC+4, sign-extended immediate.
REQ-006 ALUResultMH  input  32  forwarded M-stage ALU result.
REQ-007 ResultW  input  32  forwarded W-stage result.
REQ-008 RdE  input  5  destination register.
REQ-009 funct3E  input  3  branch condition select.
REQ-010 controlE  input  11  control bits, fields:
- [0] ALUSrc
- [4:1] ALUControl
- [6:5] flow: 00 none, 01 branch, 10 jal, 11 jalr
- [10:7] M-stage control
REQ-011 ForwardAE, ForwardBE  input  2 each  operand forwarding selects.
REQ-012 PCTargetE  output  32  PCE+ImmExtE.
REQ-013 ALUResultE  output  32  combinational ALU result.
REQ-014 PCSrcE  output  2  next-PC select: 00 PC+4, 01 PCTargetE, 10 ALUResultE.
REQ-015 ALUResultM, WriteDataM, PCPlus4M  output  32 each  registered outputs.
REQ-016 RdM  output  5  registered RdE.
REQ-017 controlM  output  4  registered controlE[10:7].

Function
REQ-018 SrcA SHALL be selected by ForwardAE: 00 RD1E, 01 ResultW, 10 ALUResultMH, 11 RD1E.
REQ-019 SrcBo SHALL be selected by ForwardBE with the same encoding, using RD2E.
REQ-020 SrcB SHALL be SrcBo when ALUSrc=0 and ImmExtE when ALUSrc=1.
REQ-021 ALU operations by ALUControl (32-bit, wrap-around, no overflow trap):
- 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
- 0101 SLT signed (result 1/0), 0110 SLTU unsigned (result 1/0)
- 0111 SLL, 1000 SRL, 1001 SRA; shift amount = SrcB[4:0]
- 1010 pass SrcB
- 1011-1111 result 0
REQ-022 ALU flags SHALL be combinational and independent of ALUControl:
- Zero = (SrcA==SrcB)
- Sign = signed SrcA<SrcB
- Slt = unsigned SrcA<SrcB
REQ-023 PCTargetE SHALL be PCE+ImmExtE modulo 2^32, combinational.
REQ-024 PCSrcE when flow=01 (branch): 01 if taken, else 00. Taken condition by funct3E:
- 000 Zero; 001 !Zero
- 100 Sign; 101 !Sign
- 110 Slt; 111 !Slt
- 010/011 never taken
REQ-025 PCSrcE SHALL be 00 for flow=00, 01 for flow=10, and 10 for flow=11.
REQ-026 On each rising CLK edge with RST=0, the register SHALL load:
- ALUResultM <= ALUResultE, WriteDataM <= SrcBo (forwarded, pre-immediate mux)
- PCPlus4M <= PCPlus4E, RdM <= RdE, controlM <= controlE[10:7]
REQ-027 Latency SHALL be zero cycles for combinational outputs and one cycle for M outputs; no stall/flush inputs, no handshake.

Reset
REQ-028 On a rising CLK edge with RST=1, ALUResultM, WriteDataM, PCPlus4M, RdM and controlM SHALL all become 0.
REQ-029 Reset SHALL take priority over the data load; combinational outputs SHALL be unaffected by RST.
REQ-030 All registered outputs SHALL also initialize to 0 at power-up.

Verification
REQ-031 RD1E=5, RD2E=7, ForwardAE/BE=00, ALUSrc=0, ALUControl=0001 -> ALUResultE=0xFFFFFFFE, Sign=1, Slt=1; after the edge, ALUResultM=0xFFFFFFFE and WriteDataM=7.
REQ-032 RD1E=0xFFFFFFFF, RD2E=1, flow=01, funct3=100 -> PCSrcE=01 (signed -1<1); same operands with funct3=110 -> PCSrcE=00.
REQ-033 ForwardAE=10, ALUResultMH=0x10, ForwardBE=01, ResultW=0x20, ALUSrc=1, ImmExtE=4, ADD -> ALUResultE=0x14; after the edge, WriteDataM=0x20.
REQ-034 PCE=0x100, ImmExtE=0xFFFFFFF8 -> PCTargetE=0xF8; flow=10 -> PCSrcE=01; flow=11 -> PCSrcE=10.
REQ-035 SrcA=0x80000000, SrcB=4: SRA -> 0xF8000000; SRL -> 0x08000000; ALUControl=1111 -> 0.
REQ-036 Load all M registers with nonzero values, then assert RST for one edge -> all M outputs read 0 after that edge; deassert RST -> normal loading resumes on the next edge.
